// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light interface monitor: colour codes,
// error-flag bit positions and small arithmetic helpers.
package semaforo_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    localparam int ERR_ENC  = 0;
    localparam int ERR_SEQ  = 1;
    localparam int ERR_CONF = 2;
    localparam int ERR_TIME = 3;

    typedef enum logic [1:0] {
        ST_NOHIST = 2'd0,
        ST_G      = 2'd1,
        ST_Y      = 2'd2,
        ST_R      = 2'd3
    } light_st_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'd255) ? v : v + 8'd1;
    endfunction

    function automatic logic [2:0] st_to_colour(input light_st_e st);
        logic [2:0] c;
        case (st)
            ST_G:    c = GREEN;
            ST_Y:    c = YELLOW;
            ST_R:    c = RED;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/light_tracker.sv
// Tracks one light's colour and dwell time; flags invalid codes and
// out-of-order colour changes for the sample currently on the bus.
module light_tracker
    import semaforo_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    output logic [2:0] cur,
    output logic [7:0] dwell,
    output logic       changed,
    output logic [2:0] prev,
    output logic [7:0] prev_dwell,
    output logic       seq_err,
    output logic       enc_err
);

    light_st_e  state_r;
    light_st_e  light_st_s;
    logic [7:0] dwell_r;
    logic       changed_s;
    logic       legal_s;

    // Decode the sampled bus value; anything not one-hot is treated as no history.
    always_comb begin
        light_st_s = ST_NOHIST;
        case (light)
            GREEN:   light_st_s = ST_G;
            YELLOW:  light_st_s = ST_Y;
            RED:     light_st_s = ST_R;
            default: light_st_s = ST_NOHIST;
        endcase
    end

    // Classify a colour change against the only legal successor of the held colour.
    always_comb begin
        legal_s   = 1'b0;
        changed_s = 1'b0;
        if ((state_r != ST_NOHIST) && (light_st_s != ST_NOHIST) && (light_st_s != state_r)) begin
            changed_s = 1'b1;
        end else begin
            changed_s = 1'b0;
        end
        case (state_r)
            ST_G:    legal_s = (light_st_s == ST_Y);
            ST_Y:    legal_s = (light_st_s == ST_R);
            ST_R:    legal_s = (light_st_s == ST_G);
            default: legal_s = 1'b0;
        endcase
    end

    // Tracker state and saturating dwell counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_NOHIST;
            dwell_r <= 8'd0;
        end else if (light_st_s == ST_NOHIST) begin
            state_r <= ST_NOHIST;
            dwell_r <= 8'd0;
        end else if (light_st_s == state_r) begin
            dwell_r <= sat_inc8(dwell_r);
        end else begin
            state_r <= light_st_s;
            dwell_r <= 8'd1;
        end
    end

    assign cur        = st_to_colour(state_r);
    assign dwell      = dwell_r;
    assign changed    = changed_s;
    assign prev       = st_to_colour(state_r);
    assign prev_dwell = dwell_r;
    assign seq_err    = changed_s & ~legal_s;
    assign enc_err    = (light_st_s == ST_NOHIST);

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker for the two-way traffic-light interface: encoding, sequence,
// conflicting-green and dwell-time violations with sticky flags and a counter.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter logic [7:0] VERDE        = 8'd1,
    parameter logic [7:0] AMARELO      = 8'd3,
    parameter logic [7:0] VERMELHO     = 8'd2,
    parameter logic       CHECK_TIMING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [3:0] err,
    output logic       err_pulse,
    output logic [7:0] viol_cnt,
    output logic [7:0] dwell_a
);

    logic [2:0] cur_a_s, prev_a_s, cur_b_s, prev_b_s;
    logic [7:0] dwell_a_s, prev_dwell_a_s, dwell_b_s, prev_dwell_b_s;
    logic       changed_a_s, changed_b_s;
    logic       seq_a_s, seq_b_s, enc_a_s, enc_b_s;
    logic       time_bad_s;
    logic [3:0] new_err_s;
    logic [3:0] err_r;
    logic       err_pulse_r;
    logic [7:0] viol_cnt_r;
    logic       unused_s;

    light_tracker u_trk_a (
        .clk        (clk),
        .rst        (rst),
        .light      (A),
        .cur        (cur_a_s),
        .dwell      (dwell_a_s),
        .changed    (changed_a_s),
        .prev       (prev_a_s),
        .prev_dwell (prev_dwell_a_s),
        .seq_err    (seq_a_s),
        .enc_err    (enc_a_s)
    );

    light_tracker u_trk_b (
        .clk        (clk),
        .rst        (rst),
        .light      (B),
        .cur        (cur_b_s),
        .dwell      (dwell_b_s),
        .changed    (changed_b_s),
        .prev       (prev_b_s),
        .prev_dwell (prev_dwell_b_s),
        .seq_err    (seq_b_s),
        .enc_err    (enc_b_s)
    );

    // B is only checked for encoding and sequence, so its dwell information is not consumed.
    assign unused_s = ^{cur_a_s, cur_b_s, dwell_b_s, changed_b_s, prev_b_s, prev_dwell_b_s};

    // Dwell window of the colour A is leaving.
    always_comb begin
        time_bad_s = 1'b0;
        case (prev_a_s)
            GREEN:   time_bad_s = (prev_dwell_a_s == 8'd0) || (prev_dwell_a_s > VERDE);
            YELLOW:  time_bad_s = (prev_dwell_a_s != AMARELO);
            RED:     time_bad_s = (prev_dwell_a_s != VERMELHO);
            default: time_bad_s = 1'b0;
        endcase
    end

    // Violations present in the current sample.
    always_comb begin
        new_err_s           = 4'b0000;
        new_err_s[ERR_ENC]  = enc_a_s | enc_b_s;
        new_err_s[ERR_SEQ]  = seq_a_s | seq_b_s;
        new_err_s[ERR_CONF] = ~enc_a_s & ~enc_b_s & (A != RED) & (B != RED);
        if (CHECK_TIMING) begin
            new_err_s[ERR_TIME] = changed_a_s & time_bad_s;
        end else begin
            new_err_s[ERR_TIME] = 1'b0;
        end
    end

    // Sticky flags, one-cycle pulse and saturating event counter (one event per sample).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r       <= 4'b0000;
            err_pulse_r <= 1'b0;
            viol_cnt_r  <= 8'd0;
        end else begin
            err_r       <= err_r | new_err_s;
            err_pulse_r <= |new_err_s;
            if (|new_err_s) begin
                viol_cnt_r <= sat_inc8(viol_cnt_r);
            end else begin
                viol_cnt_r <= viol_cnt_r;
            end
        end
    end

    assign err       = err_r;
    assign err_pulse = err_pulse_r;
    assign viol_cnt  = viol_cnt_r;
    assign dwell_a   = dwell_a_s;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Randomised and directed bench for semaforo_monitor against a colour-index
// reference model; a second instance runs with timing checks disabled.
module tb_semaforo_monitor;

    localparam logic [2:0] CG = 3'b001;
    localparam logic [2:0] CY = 3'b010;
    localparam logic [2:0] CR = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] A, B;
    logic [3:0] err_t, err_n;
    logic       pulse_t, pulse_n;
    logic [7:0] cnt_t, cnt_n, dwell_t, dwell_n;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: colour index 0=G,1=Y,2=R, -1 = no history
    int         m_hist[2];
    int         m_dwell[2];
    logic [3:0] m_err[2];
    logic       m_pulse[2];
    int         m_cnt[2];
    int         lim_lo[3] = '{1, 3, 2};
    int         lim_hi[3] = '{1, 3, 2};
    logic [2:0] cols[3]   = '{CG, CY, CR};

    semaforo_monitor dut (
        .clk(clk), .rst(rst), .A(A), .B(B),
        .err(err_t), .err_pulse(pulse_t), .viol_cnt(cnt_t), .dwell_a(dwell_t)
    );

    semaforo_monitor #(.CHECK_TIMING(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .A(A), .B(B),
        .err(err_n), .err_pulse(pulse_n), .viol_cnt(cnt_n), .dwell_a(dwell_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int col_idx(input logic [2:0] c);
        if (c == CG) return 0;
        if (c == CY) return 1;
        if (c == CR) return 2;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hist[k] = -1; m_dwell[k] = 0;
            m_err[k] = 4'b0; m_pulse[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_step(input logic [2:0] a, input logic [2:0] b);
        int         idx[2];
        logic [3:0] v;
        logic [3:0] vk;
        logic       tv;
        idx[0] = col_idx(a);
        idx[1] = col_idx(b);
        v  = 4'b0;
        tv = 1'b0;
        if (idx[0] < 0 || idx[1] < 0) v[0] = 1'b1;
        if (idx[0] >= 0 && idx[1] >= 0 && idx[0] != 2 && idx[1] != 2) v[2] = 1'b1;
        for (int l = 0; l < 2; l++) begin
            if (idx[l] >= 0 && m_hist[l] >= 0 && idx[l] != m_hist[l]) begin
                if (idx[l] != (m_hist[l] + 1) % 3) v[1] = 1'b1;
                if (l == 0 && (m_dwell[0] < lim_lo[m_hist[0]] || m_dwell[0] > lim_hi[m_hist[0]]))
                    tv = 1'b1;
            end
            if (idx[l] < 0) begin
                m_hist[l] = -1; m_dwell[l] = 0;
            end else if (idx[l] == m_hist[l]) begin
                m_dwell[l] = (m_dwell[l] >= 255) ? 255 : m_dwell[l] + 1;
            end else begin
                m_hist[l] = idx[l]; m_dwell[l] = 1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            vk = v;
            if (k == 0) vk[3] = tv;
            m_err[k]   = m_err[k] | vk;
            m_pulse[k] = |vk;
            if (|vk) m_cnt[k] = (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
        end
    endtask

    task automatic compare_all();
        chk("err",         err_t,   m_err[0]);
        chk("err_pulse",   pulse_t, m_pulse[0]);
        chk("viol_cnt",    cnt_t,   m_cnt[0]);
        chk("dwell_a",     dwell_t, m_dwell[0]);
        chk("nt_err",      err_n,   m_err[1]);
        chk("nt_err_pulse", pulse_n, m_pulse[1]);
        chk("nt_viol_cnt", cnt_n,   m_cnt[1]);
        chk("nt_dwell_a",  dwell_n, m_dwell[0]);
    endtask

    // entered and left at a falling edge
    task automatic cycle(input logic [2:0] a, input logic [2:0] b);
        A = a;
        B = b;
        @(posedge clk);
        if (rst) model_step(a, b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        rst = 1'b1;
    endtask

    initial begin
        logic [2:0] seq_a[$];
        int         exp_dw[$];
        int         cur;
        int         hold;
        logic [2:0] av, bv;

        rst = 1'b0;
        A = 3'b000;
        B = 3'b000;
        model_reset();
        @(negedge clk);

        // T1: reset held with random buses
        do_reset();
        chk("t1_err", err_t, 4'b0000);
        chk("t1_cnt", cnt_t, 8'd0);

        // T2: legal cycle with default timing
        do_reset();
        seq_a  = '{CG, CY, CY, CY, CR, CR, CG};
        exp_dw = '{1, 1, 2, 3, 1, 2, 1};
        foreach (seq_a[i]) begin
            cycle(seq_a[i], CR);
            chk("t2_dwell", dwell_t, 32'(exp_dw[i]));
        end
        chk("t2_err", err_t, 4'b0000);

        // T3: illegal G->R, then a legal R->G
        do_reset();
        cycle(CG, CR);
        cycle(CR, CR);
        chk("t3_pulse", pulse_t, 1'b1);
        cycle(CR, CR);
        chk("t3_pulse_low", pulse_t, 1'b0);
        cycle(CG, CR);
        chk("t3_err", err_t, 4'b0010);
        chk("t3_cnt", cnt_t, 8'd1);

        // T4: conflicting greens for two samples
        do_reset();
        cycle(CG, CY);
        cycle(CG, CY);
        chk("t4_err", err_t, 4'b0100);
        chk("t4_cnt", cnt_t, 8'd2);

        // T5a: yellow cut short by an invalid code, then red from no history
        do_reset();
        cycle(CY, CR);
        cycle(CY, CR);
        cycle(3'b011, CR);
        cycle(CR, CR);
        chk("t5a_err", err_t, 4'b0001);
        chk("t5a_cnt", cnt_t, 8'd1);

        // T5b: yellow too short into red
        do_reset();
        cycle(CY, CR);
        cycle(CY, CR);
        cycle(CR, CR);
        chk("t5b_err", err_t, 4'b1000);
        chk("t5b_nt_err", err_n, 4'b0000);

        // T6: dwell saturation, then asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 300; i++) cycle(CR, CR);
        chk("t6_dwell_sat", dwell_t, 8'd255);
        #2 rst = 1'b0;
        model_reset();
        #1 compare_all();
        chk("t6_async_dwell", dwell_t, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // Random segments: mostly legal progressions with random holds, some noise
        do_reset();
        cur = 0;
        for (int s = 0; s < 700; s++) begin
            if ($urandom_range(0, 99) < 80) cur = (cur + 1) % 3;
            else cur = $urandom_range(0, 2);
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                av = cols[cur];
                bv = ($urandom_range(0, 99) < 85) ? CR : cols[$urandom_range(0, 2)];
                if ($urandom_range(0, 99) < 5) av = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 99) < 3) bv = 3'($urandom_range(0, 7));
                cycle(av, bv);
            end
            if (s == 350) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
